dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning the word-address width (64-word data memory).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data word width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cpu_req_valid input 1, cpu_req_we input 1, cpu_req_addr input ADDR_W, cpu_req_wdata input DATA_W, cpu_req_ready output 1: the CPU load/store request channel.
REQ-006 SHALL have ports cpu_rsp_valid output 1 and cpu_rsp_rdata output DATA_W: the CPU response channel.
REQ-007 SHALL have ports dbg_req_valid, dbg_req_we, dbg_req_lock, dbg_req_addr, dbg_req_wdata (inputs) and dbg_req_ready (output): the debug/loader request channel, widths as the CPU channel, with dbg_req_lock 1 bit.
REQ-008 SHALL have ports dbg_rsp_valid output 1 and dbg_rsp_rdata output DATA_W.
REQ-009 SHALL have ports mem_en, mem_we (outputs, 1), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W) and mem_rdata (input, DATA_W): a single-port synchronous memory with 1-cycle read latency.

Function
REQ-010 SHALL issue at most one memory access per cycle; a request is accepted on a cycle where valid && ready.
REQ-011 SHALL drive ready combinationally: ready is high only for the granted requester, and only when that requester's valid is high.
REQ-012 SHALL arbitrate round-robin in state ARB: with both valid, grant the requester not granted last; with one valid, grant it.
REQ-013 SHALL update last_grant only on an accepted request.
REQ-014 SHALL drive mem_en=1 and mem_we/addr/wdata from the granted request in the accept cycle, and mem_en=0 otherwise.
REQ-015 SHALL assert the owner's rsp_valid exactly 1 cycle after acceptance, for reads and writes. rsp_rdata SHALL be mem_rdata for reads and 0 for writes.
REQ-016 SHALL hold the non-owner's rsp_valid at 0, and rsp_rdata at 0 whenever rsp_valid is 0.
REQ-017 SHALL transition ARB->LOCKED when a dbg request is accepted with dbg_req_lock=1.
REQ-018 SHALL grant only dbg in LOCKED, with cpu_req_ready=0.
REQ-019 SHALL return LOCKED->ARB on the first accepted dbg request with dbg_req_lock=0, which is itself serviced.
REQ-020 SHALL, in LOCKED with dbg_req_valid=0, issue no access and remain LOCKED.
REQ-021 SHALL keep back-to-back accepts legal: a response and a new access can coincide in the same cycle.
REQ-022 SHALL ignore cpu_req_we, addr and wdata while cpu_req_valid=0, and likewise for dbg.

Reset
REQ-023 SHALL, on reset low, asynchronously force state=ARB, last_grant=dbg (so CPU wins the first tie), response tag invalid, all ready/rsp_valid/mem_en/mem_we=0, and mem_addr/mem_wdata/rsp_rdata=0.
REQ-024 SHALL discard a response pending when reset asserts mid-operation, with no rsp_valid after release.
REQ-025 SHALL accept a request on the first rising edge after reset deasserts.

Structure
REQ-026 SHALL place the state encoding (ARB, LOCKED), the requester IDs (REQ_CPU=0, REQ_DBG=1) and the default ADDR_W/DATA_W in a shared package, mips32_pkg.
REQ-027 SHALL factor the two-way round-robin pick into a sub-module rr_arb2 (inputs: req[1:0], last; output: grant one-hot); the FSM and response-tag pipeline stay in dmem_arbiter.

Verification
REQ-028 SHALL cover: CPU-only read addr 5 with mem[5]=0x1234ABCD -> cpu_req_ready same cycle, cpu_rsp_valid next cycle with rdata 0x1234ABCD, dbg_rsp_valid 0.
REQ-029 SHALL cover: both valid for 4 cycles after reset -> grants CPU, DBG, CPU, DBG; each rsp_valid 1 cycle after its grant.
REQ-030 SHALL cover: dbg write lock=1 addr 0 data 0xA, then CPU valid plus dbg writes lock=1 addr 1, lock=0 addr 2 -> cpu_req_ready 0 for 3 cycles; CPU granted the cycle after the lock=0 accept.
REQ-031 SHALL cover: LOCKED with dbg idle 5 cycles and CPU valid -> mem_en 0 and cpu_req_ready 0 throughout.
REQ-032 SHALL cover: CPU read accepted, then reset low for 1 cycle before the response -> cpu_rsp_valid never asserts and all outputs 0 during reset.
REQ-033 SHALL cover: CPU write 0xDEADBEEF to addr 63, then read addr 63 -> write rsp rdata 0; read rsp rdata 0xDEADBEEF.

Source files
------------

// File: rtl/mips32_pkg.sv
// mips32_pkg -- definitions shared by the data-memory arbiter and its
// round-robin pick: arbiter state encoding, requester IDs and the default
// memory geometry (64 x 32-bit words).
package mips32_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 32;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DBG = 1'b1
   } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin pick.
// Ports:
//   req   [1:0]  request vector, bit REQ_CPU / bit REQ_DBG
//   last         requester granted on the most recent accepted request
//   grant [1:0]  one-hot grant (all zero when nobody requests)
module rr_arb2
   import mips32_pkg::*;
(
   input  logic [1:0] req,
   input  req_id_e    last,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      // On a tie the requester that did not win last time gets the slot.
      if (req == 2'b11) begin
         grant = (last == REQ_DBG) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares one single-port synchronous data memory (1-cycle
// read latency) between the CPU load/store port and a debug/loader port.
// Round-robin between the two; the debug port can lock the memory for a
// burst (LOCKED) by issuing requests with dbg_req_lock=1, and releases it
// with its first accepted request carrying dbg_req_lock=0.
// Ports:
//   clk, reset (async, active-low)
//   cpu_req_*  / cpu_rsp_*   CPU request (valid/ready) and response
//   dbg_req_*  / dbg_rsp_*   debug request (valid/ready, lock) and response
//   mem_*                    memory command outputs, mem_rdata input
module dmem_arbiter
   import mips32_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              cpu_req_valid,
   input  logic              cpu_req_we,
   input  logic [ADDR_W-1:0] cpu_req_addr,
   input  logic [DATA_W-1:0] cpu_req_wdata,
   output logic              cpu_req_ready,
   output logic              cpu_rsp_valid,
   output logic [DATA_W-1:0] cpu_rsp_rdata,

   input  logic              dbg_req_valid,
   input  logic              dbg_req_we,
   input  logic              dbg_req_lock,
   input  logic [ADDR_W-1:0] dbg_req_addr,
   input  logic [DATA_W-1:0] dbg_req_wdata,
   output logic              dbg_req_ready,
   output logic              dbg_rsp_valid,
   output logic [DATA_W-1:0] dbg_rsp_rdata,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e state_q, state_d;
   req_id_e    last_q;
   logic [1:0] arb_req;
   logic [1:0] rr_grant;
   logic [1:0] grant;
   logic       accept;
   req_id_e    acc_id;

   // Response tag: who owns the access issued last cycle, and whether it
   // was a write (writes return zero data).
   logic       rsp_vld_p1;
   req_id_e    rsp_own_p1;
   logic       rsp_we_p1;

   assign arb_req = {dbg_req_valid, cpu_req_valid};

   rr_arb2 u_rr_arb2 (
      .req   (arb_req),
      .last  (last_q),
      .grant (rr_grant)
   );

   always_comb begin
      grant = 2'b00;
      // Gating with reset keeps every command output at zero while the
      // block is held in reset, even with requests pending.
      if (reset) begin
         if (state_q == LOCKED) begin
            grant = {dbg_req_valid, 1'b0};
         end else begin
            grant = rr_grant;
         end
      end
   end

   assign accept        = |grant;
   assign acc_id        = grant[1] ? REQ_DBG : REQ_CPU;
   assign cpu_req_ready = grant[0];
   assign dbg_req_ready = grant[1];

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant[0]) begin
         mem_en    = 1'b1;
         mem_we    = cpu_req_we;
         mem_addr  = cpu_req_addr;
         mem_wdata = cpu_req_wdata;
      end else if (grant[1]) begin
         mem_en    = 1'b1;
         mem_we    = dbg_req_we;
         mem_addr  = dbg_req_addr;
         mem_wdata = dbg_req_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      // An accepted debug request sets the lock state from its lock bit:
      // lock=1 enters/stays LOCKED, lock=0 leaves/stays in ARB.
      if (grant[1]) begin
         state_d = dbg_req_lock ? LOCKED : ARB;
      end
   end

   // ---- accept stage -> response stage (p1) ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ARB;
         last_q     <= REQ_DBG;
         rsp_vld_p1 <= 1'b0;
         rsp_own_p1 <= REQ_CPU;
         rsp_we_p1  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rsp_vld_p1 <= accept;
         if (accept) begin
            last_q     <= acc_id;
            rsp_own_p1 <= acc_id;
            rsp_we_p1  <= mem_we;
         end
      end
   end

   always_comb begin
      cpu_rsp_valid = rsp_vld_p1 && (rsp_own_p1 == REQ_CPU);
      dbg_rsp_valid = rsp_vld_p1 && (rsp_own_p1 == REQ_DBG);
      cpu_rsp_rdata = (cpu_rsp_valid && !rsp_we_p1) ? mem_rdata : '0;
      dbg_rsp_rdata = (dbg_rsp_valid && !rsp_we_p1) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req_valid, cpu_req_we, cpu_req_ready, cpu_rsp_valid;
   logic [5:0]  cpu_req_addr;
   logic [31:0] cpu_req_wdata, cpu_rsp_rdata;
   logic        dbg_req_valid, dbg_req_we, dbg_req_lock, dbg_req_ready, dbg_rsp_valid;
   logic [5:0]  dbg_req_addr;
   logic [31:0] dbg_req_wdata, dbg_rsp_rdata;
   logic        mem_en, mem_we;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .cpu_req_valid (cpu_req_valid),
      .cpu_req_we    (cpu_req_we),
      .cpu_req_addr  (cpu_req_addr),
      .cpu_req_wdata (cpu_req_wdata),
      .cpu_req_ready (cpu_req_ready),
      .cpu_rsp_valid (cpu_rsp_valid),
      .cpu_rsp_rdata (cpu_rsp_rdata),
      .dbg_req_valid (dbg_req_valid),
      .dbg_req_we    (dbg_req_we),
      .dbg_req_lock  (dbg_req_lock),
      .dbg_req_addr  (dbg_req_addr),
      .dbg_req_wdata (dbg_req_wdata),
      .dbg_req_ready (dbg_req_ready),
      .dbg_rsp_valid (dbg_rsp_valid),
      .dbg_rsp_rdata (dbg_rsp_rdata),
      .mem_en        (mem_en),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata)
   );

   // Behavioural single-port memory, 1-cycle read latency.
   logic [31:0] mem [64];
   logic        mem_init = 1'b0;
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h100 + i;
         mem[5]    <= 32'h1234ABCD;
         mem_rdata <= '0;
         mem_init  <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   typedef struct {
      logic        cv, cwe;
      logic [5:0]  ca;
      logic [31:0] cd;
      logic        dv, dwe, dl;
      logic [5:0]  da;
      logic [31:0] dd;
      logic        e_cr, e_dr, e_en, e_we;
      logic [5:0]  e_a;
      logic [31:0] e_d;
      logic        e_cv;
      logic [31:0] e_crd;
      logic        e_dv;
      logic [31:0] e_drd;
   } vec_t;

   vec_t vecs [22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic cv, input logic cwe, input logic [5:0] ca, input logic [31:0] cd,
                        input logic dv, input logic dwe, input logic dl, input logic [5:0] da,
                        input logic [31:0] dd);
      cpu_req_valid = cv;  cpu_req_we = cwe;  cpu_req_addr = ca;  cpu_req_wdata = cd;
      dbg_req_valid = dv;  dbg_req_we = dwe;  dbg_req_lock = dl;
      dbg_req_addr  = da;  dbg_req_wdata = dd;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".cpu_ready"}, cpu_req_ready, 0);
      chk({tag, ".dbg_ready"}, dbg_req_ready, 0);
      chk({tag, ".mem_en"},    mem_en, 0);
      chk({tag, ".mem_we"},    mem_we, 0);
      chk({tag, ".mem_addr"},  mem_addr, 0);
      chk({tag, ".mem_wdata"}, mem_wdata, 0);
      chk({tag, ".cpu_rsp_v"}, cpu_rsp_valid, 0);
      chk({tag, ".cpu_rdata"}, cpu_rsp_rdata, 0);
      chk({tag, ".dbg_rsp_v"}, dbg_rsp_valid, 0);
      chk({tag, ".dbg_rdata"}, dbg_rsp_rdata, 0);
   endtask

   initial begin
      //          cv cwe ca  cd            dv dwe dl da dd       cr dr en we a   d            cv crd           dv drd
      // Both requesting: strict alternation starting with CPU after reset.
      vecs[0]  = '{1,0, 1, 0,            1,0,0, 2, 0,      1,0,1,0, 1, 0,           0,0,            0,0};
      vecs[1]  = '{1,0, 1, 0,            1,0,0, 2, 0,      0,1,1,0, 2, 0,           1,32'h101,      0,0};
      vecs[2]  = '{1,0, 1, 0,            1,0,0, 2, 0,      1,0,1,0, 1, 0,           0,0,            1,32'h102};
      vecs[3]  = '{1,0, 1, 0,            1,0,0, 2, 0,      0,1,1,0, 2, 0,           1,32'h101,      0,0};
      // CPU-only read of address 5.
      vecs[4]  = '{1,0, 5, 0,            0,0,0, 0, 0,      1,0,1,0, 5, 0,           0,0,            1,32'h102};
      vecs[5]  = '{0,0, 0, 0,            0,0,0, 0, 0,      0,0,0,0, 0, 0,           1,32'h1234ABCD, 0,0};
      // Write then read back the top word.
      vecs[6]  = '{1,1,63, 32'hDEADBEEF, 0,0,0, 0, 0,      1,0,1,1,63, 32'hDEADBEEF,0,0,            0,0};
      vecs[7]  = '{1,0,63, 0,            0,0,0, 0, 0,      1,0,1,0,63, 0,           1,0,            0,0};
      vecs[8]  = '{0,0, 0, 0,            0,0,0, 0, 0,      0,0,0,0, 0, 0,           1,32'hDEADBEEF, 0,0};
      // Debug lock burst with CPU waiting.
      vecs[9]  = '{0,0, 0, 0,            1,1,1, 0, 32'hA,  0,1,1,1, 0, 32'hA,       0,0,            0,0};
      vecs[10] = '{1,0, 3, 0,            1,1,1, 1, 32'hB,  0,1,1,1, 1, 32'hB,       0,0,            1,0};
      vecs[11] = '{1,0, 3, 0,            1,1,0, 2, 32'hC,  0,1,1,1, 2, 32'hC,       0,0,            1,0};
      vecs[12] = '{1,0, 3, 0,            0,0,0, 0, 0,      1,0,1,0, 3, 0,           0,0,            1,0};
      // Lock, then debug idle for five cycles while CPU waits.
      vecs[13] = '{0,0, 0, 0,            1,1,1, 4, 32'h55, 0,1,1,1, 4, 32'h55,      1,32'h103,      0,0};
      vecs[14] = '{1,0, 6, 0,            0,0,0, 0, 0,      0,0,0,0, 0, 0,           0,0,            1,0};
      vecs[15] = '{1,0, 6, 0,            0,0,0, 0, 0,      0,0,0,0, 0, 0,           0,0,            0,0};
      vecs[16] = '{1,0, 6, 0,            0,0,0, 0, 0,      0,0,0,0, 0, 0,           0,0,            0,0};
      vecs[17] = '{1,0, 6, 0,            0,0,0, 0, 0,      0,0,0,0, 0, 0,           0,0,            0,0};
      vecs[18] = '{1,0, 6, 0,            0,0,0, 0, 0,      0,0,0,0, 0, 0,           0,0,            0,0};
      vecs[19] = '{1,0, 6, 0,            1,0,0, 4, 0,      0,1,1,0, 4, 0,           0,0,            0,0};
      vecs[20] = '{1,0, 6, 0,            0,0,0, 0, 0,      1,0,1,0, 6, 0,           0,0,            1,32'h55};
      // Junk on invalid channels must not reach the memory port.
      vecs[21] = '{0,1, 7, 32'hFFFF,     0,1,1, 9, 32'hEEEE,0,0,0,0, 0, 0,          1,32'h106,      0,0};

      // Reset held with requests pending: everything must read zero.
      reset = 1'b0;
      drive(1, 1, 6'd9, 32'h77, 1, 1, 1, 6'd8, 32'h66);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk_all_zero("reset");
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         drive(vecs[i].cv, vecs[i].cwe, vecs[i].ca, vecs[i].cd,
               vecs[i].dv, vecs[i].dwe, vecs[i].dl, vecs[i].da, vecs[i].dd);
         #1;
         chk($sformatf("v%0d.cpu_ready", i), cpu_req_ready, vecs[i].e_cr);
         chk($sformatf("v%0d.dbg_ready", i), dbg_req_ready, vecs[i].e_dr);
         chk($sformatf("v%0d.mem_en", i),    mem_en,        vecs[i].e_en);
         chk($sformatf("v%0d.mem_we", i),    mem_we,        vecs[i].e_we);
         chk($sformatf("v%0d.mem_addr", i),  mem_addr,      vecs[i].e_a);
         chk($sformatf("v%0d.mem_wdata", i), mem_wdata,     vecs[i].e_d);
         chk($sformatf("v%0d.cpu_rsp_v", i), cpu_rsp_valid, vecs[i].e_cv);
         chk($sformatf("v%0d.cpu_rdata", i), cpu_rsp_rdata, vecs[i].e_crd);
         chk($sformatf("v%0d.dbg_rsp_v", i), dbg_rsp_valid, vecs[i].e_dv);
         chk($sformatf("v%0d.dbg_rdata", i), dbg_rsp_rdata, vecs[i].e_drd);
      end

      // CPU read accepted, reset pulsed before its response is observed.
      @(negedge clk);
      drive(1, 0, 6'd5, 0, 0, 0, 0, 0, 0);
      #1;
      chk("mid.accept", cpu_req_ready, 1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk); #1;
      chk_all_zero("mid.reset");
      // Release and present a read immediately: first edge must accept it,
      // and the discarded response must not appear.
      reset = 1'b1;
      drive(1, 0, 6'd5, 0, 0, 0, 0, 0, 0);
      #1;
      chk("post.cpu_ready", cpu_req_ready, 1);
      chk("post.cpu_rsp_v", cpu_rsp_valid, 0);
      chk("post.dbg_rsp_v", dbg_rsp_valid, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("post.rsp_v",   cpu_rsp_valid, 1);
      chk("post.rdata",   cpu_rsp_rdata, 32'h1234ABCD);
      chk("post.dbg_v",   dbg_rsp_valid, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         chk($sformatf("idle%0d.cpu_rsp_v", k), cpu_rsp_valid, 0);
         chk($sformatf("idle%0d.mem_en", k),    mem_en, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
